// File: rtl/spi_command_queue.sv
// Captures SPI command bytes once per data_valid assertion, rejects malformed bytes,
// and queues well-formed commands in a small FIFO presented over valid/ready.
module spi_command_queue #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               spi_data,
    input  logic                     spi_data_valid,
    output logic                     spi_clear,
    output logic [1:0]               cmd_move,
    output logic                     cmd_move_valid,
    output logic [2:0]               cmd_piece_sel,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_WIDTH-1:0]     drop_count,
    output logic [CNT_WIDTH-1:0]     error_count,
    output logic [1:0]               capture_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]          FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    // Handshake: cmd_valid is high whenever the FIFO holds an entry; the head
    // entry is consumed on any clock edge where cmd_valid && cmd_ready.

    state_t         state;
    state_t         state_next;
    logic [1:0]     sync_q;
    logic           vs;
    logic [5:0]     mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [5:0]     head;
    logic           capture;
    logic           malformed;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;
    logic           reject;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], spi_data_valid};
        end
    end

    assign vs = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            spi_clear <= 1'b0;
        end else begin
            state     <= state_next;
            spi_clear <= (state_next == CLEAR);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vs) state_next = CAPTURE;
            CAPTURE: state_next = CLEAR;
            CLEAR:   if (!vs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign capture_state = state;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign capture   = (state == CAPTURE);
    assign malformed = (spi_data[7:6] != 2'b00);
    assign full      = (fifo_count == FULL_COUNT);
    assign pop       = cmd_valid & cmd_ready;
    assign push      = capture & ~malformed & (~full | pop);
    assign drop      = capture & ~malformed & full & ~pop;
    assign reject    = capture & malformed;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= spi_data[5:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count  <= '0;
            error_count <= '0;
        end else begin
            if (drop && drop_count != CNT_MAX)
                drop_count <= drop_count + CNT_WIDTH'(1);
            if (reject && error_count != CNT_MAX)
                error_count <= error_count + CNT_WIDTH'(1);
        end
    end

    assign cmd_valid      = (fifo_count != '0);
    assign head           = cmd_valid ? mem[rd_ptr] : 6'd0;
    assign cmd_move       = head[1:0];
    assign cmd_piece_sel  = head[4:2];
    assign cmd_move_valid = head[5];

endmodule

// File: tb/tb_spi_command_queue.sv
// Directed bench for spi_command_queue: a queue-based command model scheduled from
// the driver's known capture latency, a per-cycle comparator, and literal checks.
module tb_spi_command_queue;

    localparam int DEPTH     = 4;
    localparam int CNT_WIDTH = 8;
    localparam int CNT_MAX   = 255;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [7:0]             spi_data = 8'h00;
    logic                   spi_data_valid = 1'b0;
    logic                   spi_clear;
    logic [1:0]             cmd_move;
    logic                   cmd_move_valid;
    logic [2:0]             cmd_piece_sel;
    logic                   cmd_valid;
    logic                   cmd_ready = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_WIDTH-1:0]   drop_count;
    logic [CNT_WIDTH-1:0]   error_count;
    logic [1:0]             capture_state;
    logic [5:0]             head6;

    int checks = 0;
    int errors = 0;

    spi_command_queue #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_data       (spi_data),
        .spi_data_valid (spi_data_valid),
        .spi_clear      (spi_clear),
        .cmd_move       (cmd_move),
        .cmd_move_valid (cmd_move_valid),
        .cmd_piece_sel  (cmd_piece_sel),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .fifo_count     (fifo_count),
        .drop_count     (drop_count),
        .error_count    (error_count),
        .capture_state  (capture_state)
    );

    assign head6 = {cmd_move_valid, cmd_piece_sel, cmd_move};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [5:0] exp_q[$];
    int         exp_drop = 0;
    int         exp_err = 0;
    logic       exp_clear = 1'b0;
    int         cap_due = 0;
    logic [7:0] cap_byte = 8'h00;
    int         clr_rise_due = 0;
    int         clr_fall_due = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            exp_drop     = 0;
            exp_err      = 0;
            exp_clear    = 1'b0;
            cap_due      = 0;
            clr_rise_due = 0;
            clr_fall_due = 0;
        end else begin
            logic popped;
            popped = cmd_ready && (exp_q.size() > 0);
            if (popped) void'(exp_q.pop_front());
            if (cap_due > 0) begin
                cap_due--;
                if (cap_due == 0) begin
                    if (cap_byte[7:6] != 2'b00) begin
                        if (exp_err < CNT_MAX) exp_err++;
                    end else if (exp_q.size() >= DEPTH) begin
                        if (exp_drop < CNT_MAX) exp_drop++;
                    end else begin
                        exp_q.push_back(cap_byte[5:0]);
                    end
                end
            end
            if (clr_rise_due > 0) begin
                clr_rise_due--;
                if (clr_rise_due == 0) exp_clear = 1'b1;
            end
            if (clr_fall_due > 0) begin
                clr_fall_due--;
                if (clr_fall_due == 0) exp_clear = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("head",      int'(head6), (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
        check("cmd_valid", int'(cmd_valid), int'(exp_q.size() > 0));
        check("count",     int'(fifo_count), exp_q.size());
        check("drop",      int'(drop_count), exp_drop);
        check("error",     int'(error_count), exp_err);
        check("spi_clear", int'(spi_clear), int'(exp_clear));
    end

    // ---------------- driver tasks ----------------
    // Raise valid after edge c; capture lands on edge c+4, clear falls 3 edges after the drop.
    task automatic send_byte(input logic [7:0] b, input int hold, input logic ready_at_cap);
        @(posedge clk);
        #1;
        spi_data       = b;
        spi_data_valid = 1'b1;
        cap_byte       = b;
        cap_due        = 4;
        clr_rise_due   = 4;
        repeat (3) @(posedge clk);
        #1 cmd_ready = ready_at_cap;
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        repeat (hold - 4) @(posedge clk);
        #1;
        spi_data_valid = 1'b0;
        clr_fall_due   = 3;
        repeat (4) @(posedge clk);
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        @(posedge clk);
        #1 cmd_ready = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        settle();
        check("rst_clear", int'(spi_clear), 0);
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_head",  int'(head6), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // single byte held long: one entry only
        send_byte(8'h26, 20, 1'b0);
        settle();
        check("t1_move",   int'(cmd_move), 2);
        check("t1_piece",  int'(cmd_piece_sel), 1);
        check("t1_mvalid", int'(cmd_move_valid), 1);
        check("t1_count",  int'(fifo_count), 1);
        check("t1_clear",  int'(spi_clear), 0);
        pop_one();

        // overflow: six bytes into a 4-deep FIFO
        for (int i = 0; i < 6; i++) send_byte(8'h21 + 8'(i), 6, 1'b0);
        settle();
        check("t2_count", int'(fifo_count), 4);
        check("t2_drop",  int'(drop_count), 2);
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t2_order", int'(head6), 'h21 + i);
            pop_one();
        end
        settle();
        check("t2_empty", int'(cmd_valid), 0);

        // malformed byte
        send_byte(8'hC1, 6, 1'b0);
        settle();
        check("t3_error", int'(error_count), 1);
        check("t3_count", int'(fifo_count), 0);
        check("t3_clear", int'(spi_clear), 0);

        // full FIFO with pop during capture
        for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 6, 1'b0);
        send_byte(8'h25, 6, 1'b1);
        settle();
        check("t4_count", int'(fifo_count), 4);
        check("t4_drop",  int'(drop_count), 2);
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t4_order", int'(head6), 'h22 + i);
            pop_one();
        end

        // pointer wrap
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h20 + 8'(i), 5, 1'b0);
            settle();
            check("t5_head", int'(head6), 'h20 + i);
            pop_one();
        end
        settle();
        check("t5_count", int'(fifo_count), 0);

        // reset during CLEAR with data_valid still high
        @(posedge clk);
        #1;
        spi_data       = 8'h23;
        spi_data_valid = 1'b1;
        cap_byte       = 8'h23;
        cap_due        = 4;
        clr_rise_due   = 4;
        repeat (6) @(posedge clk);
        #1 check("t6_pre_clear", int'(spi_clear), 1);
        check("t6_pre_count", int'(fifo_count), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_clear", int'(spi_clear), 0);
        check("t6_count", int'(fifo_count), 0);
        check("t6_error", int'(error_count), 0);
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b0;
        cap_byte     = 8'h23;
        cap_due      = 4;
        clr_rise_due = 4;
        repeat (6) @(posedge clk);
        settle();
        check("t6_recap_count", int'(fifo_count), 1);
        check("t6_recap_head",  int'(head6), 'h23);
        check("t6_recap_clear", int'(spi_clear), 1);
        @(posedge clk);
        #1;
        spi_data_valid = 1'b0;
        clr_fall_due   = 3;
        repeat (4) @(posedge clk);
        pop_one();
        repeat (2) @(posedge clk);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
